// File: rtl/pfu_pkg.sv
// pfu_pkg: shared constants, redirect kinds and PC helper for the program fetch unit
package pfu_pkg;
  localparam int ADDR_W = 11;
  localparam int INSTR_W = 14;
  localparam int STACK_DEPTH = 8;
  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] RESET_VECTOR = '0;
  localparam logic [INSTR_W-1:0] NOP_WORD = 14'h0000;
  typedef enum logic [2:0] {NONE, SKIP, JMP, CALL, RET} redir_e;
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction
endpackage

// File: rtl/pfu_if.sv
// pfu_if: ROM, instruction-register and redirect signals between the fetch unit and the core
interface pfu_if;
  import pfu_pkg::*;
  logic [ADDR_W-1:0] rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] ir;
  logic ir_valid;
  logic ir_ready;
  logic [ADDR_W-1:0] ir_pc;
  logic jmp_req;
  logic call_req;
  logic ret_req;
  logic skip_req;
  logic [ADDR_W-1:0] jmp_target;
  logic stk_overflow;
  logic stk_underflow;
  modport master (
    output rom_addr, ir, ir_valid, ir_pc, stk_overflow, stk_underflow,
    input rom_data, ir_ready, jmp_req, call_req, ret_req, skip_req, jmp_target
  );
  modport slave (
    input rom_addr, ir, ir_valid, ir_pc, stk_overflow, stk_underflow,
    output rom_data, ir_ready, jmp_req, call_req, ret_req, skip_req, jmp_target
  );
endinterface

// File: rtl/pfu_call_stack.sv
// pfu_call_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module pfu_call_stack
  import pfu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic overflow,
  output logic underflow
);
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_dec;
  logic [SP_W:0] cnt;
  assign sp_dec = sp - 1'b1;
  assign top = mem[sp_dec];
  assign overflow = push && cnt == (SP_W+1)'(STACK_DEPTH);
  assign underflow = pop && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '{default: '0};
      sp <= '0;
      cnt <= '0;
    end else if (push) begin
      mem[sp] <= push_data;
      sp <= sp + 1'b1;
      cnt <= overflow ? cnt : cnt + 1'b1;
    end else if (pop) begin
      sp <= sp_dec;
      cnt <= underflow ? cnt : cnt - 1'b1;
    end
endmodule

// File: rtl/program_fetch_unit.sv
// program_fetch_unit: PC, fetch/execute instruction register and return stack for a PIC16-style core
module program_fetch_unit
  import pfu_pkg::*;
(
  input logic clk,
  input logic rst_n,
  pfu_if.master bus
);
  logic [ADDR_W-1:0] pc, ir_pc, top;
  logic [INSTR_W-1:0] ir;
  logic ir_valid, consume, advance, ovf, unf, ovf_p, unf_p;
  redir_e kind;
  assign consume = ir_valid & bus.ir_ready;
  assign advance = consume | ~ir_valid;
  assign bus.rom_addr = pc;
  assign bus.ir = ir;
  assign bus.ir_valid = ir_valid;
  assign bus.ir_pc = ir_pc;
  assign bus.stk_overflow = ovf;
  assign bus.stk_underflow = unf;
  always_comb
    kind = !consume ? NONE : bus.ret_req ? RET : bus.call_req ? CALL :
           bus.jmp_req ? JMP : bus.skip_req ? SKIP : NONE;
  pfu_call_stack stack (
    .clk(clk),
    .rst_n(rst_n),
    .push(kind == CALL),
    .pop(kind == RET),
    .push_data(pc),
    .top(top),
    .overflow(ovf_p),
    .underflow(unf_p)
  );
  // redirects flush the word fetched this cycle; skips keep the slot but turn it into a NOP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_VECTOR;
      ir <= '0;
      ir_valid <= 1'b0;
      ir_pc <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf | ovf_p;
      unf <= unf | unf_p;
      if (advance) begin
        ir_valid <= kind inside {NONE, SKIP};
        if (kind inside {RET, CALL, JMP}) pc <= kind == RET ? top : bus.jmp_target;
        else begin
          pc <= pc_inc(pc);
          ir <= kind == SKIP ? NOP_WORD : bus.rom_data;
          ir_pc <= pc;
        end
      end
    end
endmodule

// File: tb/tb_program_fetch_unit.sv
// tb_program_fetch_unit: scoreboard bench for fetch order, redirects, skips, return stack, wrap and reset
`timescale 1ns/1ps
module tb_program_fetch_unit;
  import pfu_pkg::*;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pfu_if bus ();
  program_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [INSTR_W-1:0] rom [2**ADDR_W];
  assign bus.rom_data = rom[bus.rom_addr];
  item_t exp_q[$];
  int checks = 0;
  int fails = 0;
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_stk [STACK_DEPTH];
  logic [SP_W-1:0] m_sp;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask
  function automatic item_t word_at(input logic [ADDR_W-1:0] a);
    return '{rom[a], a};
  endfunction
  // architectural model: which instruction the next consume must deliver
  always @(negedge clk) begin
    logic [ADDR_W-1:0] nxt;
    if (!rst_n) begin
      exp_q.delete();
      exp_q.push_back(word_at(RESET_VECTOR));
      m_pc = RESET_VECTOR;
      m_sp = '0;
      for (int i = 0; i < STACK_DEPTH; i++) m_stk[i] = '0;
    end else if (bus.ir_valid && bus.ir_ready) begin
      if (bus.ret_req) begin
        m_sp = m_sp - 1'b1;
        nxt = m_stk[m_sp];
        exp_q.push_back(word_at(nxt));
      end else if (bus.call_req) begin
        m_stk[m_sp] = m_pc + 1'b1;
        m_sp = m_sp + 1'b1;
        nxt = bus.jmp_target;
        exp_q.push_back(word_at(nxt));
      end else if (bus.jmp_req) begin
        nxt = bus.jmp_target;
        exp_q.push_back(word_at(nxt));
      end else if (bus.skip_req) begin
        nxt = m_pc + 1'b1;
        exp_q.push_back('{NOP_WORD, nxt});
      end else begin
        nxt = m_pc + 1'b1;
        exp_q.push_back(word_at(nxt));
      end
      m_pc = nxt;
    end
  end
  always @(negedge clk) begin
    item_t e;
    if (rst_n && bus.ir_valid && bus.ir_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard: got ir 0x%0h at 0x%0h, expected no instruction", bus.ir, bus.ir_pc);
      end else begin
        e = exp_q.pop_front();
        check("ir", bus.ir, e.instr);
        check("ir_pc", bus.ir_pc, e.pc);
      end
    end
  end
  task automatic wait_pc(input logic [ADDR_W-1:0] a);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (bus.ir_valid && bus.ir_pc == a) return;
    end
    checks++;
    fails++;
    $display("FAIL wait_pc: ir_pc 0x%0h, expected 0x%0h within 400 cycles", bus.ir_pc, a);
  endtask
  task automatic at_pc(input logic [ADDR_W-1:0] a, input redir_e k, input logic [ADDR_W-1:0] t);
    wait_pc(a);
    bus.jmp_target = t;
    bus.ret_req = k == RET;
    bus.call_req = k == CALL;
    bus.jmp_req = k == JMP;
    bus.skip_req = k == SKIP;
    @(posedge clk);
    #1;
    {bus.ret_req, bus.call_req, bus.jmp_req, bus.skip_req} = '0;
  endtask
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) rom[i] = 14'h2000 | 14'(i);
    rom[0] = 14'h3009;
    rom[1] = 14'h00A4;
    bus.ir_ready = 1'b1;
    {bus.ret_req, bus.call_req, bus.jmp_req, bus.skip_req} = '0;
    bus.jmp_target = '0;
    #12;
    check("reset rom_addr", bus.rom_addr, 0);
    check("reset ir_valid", bus.ir_valid, 0);
    check("reset ir", bus.ir, 0);
    check("reset ir_pc", bus.ir_pc, 0);
    check("reset overflow", bus.stk_overflow, 0);
    check("reset underflow", bus.stk_underflow, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("second fetch rom_addr", bus.rom_addr, 11'h002);
    at_pc(11'h00E, JMP, 11'h00B);
    check("goto bubble ir_valid", bus.ir_valid, 0);
    check("goto rom_addr", bus.rom_addr, 11'h00B);
    at_pc(11'h00D, SKIP, '0);
    check("skip nop ir", bus.ir, 14'h0000);
    check("skip nop ir_pc", bus.ir_pc, 11'h00E);
    at_pc(11'h010, CALL, 11'h020);
    at_pc(11'h025, RET, '0);
    check("call/ret overflow", bus.stk_overflow, 0);
    check("call/ret underflow", bus.stk_underflow, 0);
    wait_pc(11'h014);
    bus.ir_ready = 1'b0;
    bus.jmp_req = 1'b1;
    bus.jmp_target = 11'h100;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall ir_valid", bus.ir_valid, 1);
      check("stall ir", bus.ir, 14'h2014);
      check("stall ir_pc", bus.ir_pc, 11'h014);
      check("stall rom_addr", bus.rom_addr, 11'h015);
    end
    bus.jmp_req = 1'b0;
    bus.ir_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      at_pc(11'(11'h030 + 16 * k), CALL, 11'(11'h040 + 16 * k));
      if (k == 7) check("overflow after 8 calls", bus.stk_overflow, 0);
    end
    check("overflow after 9 calls", bus.stk_overflow, 1);
    at_pc(11'h0C0, RET, '0);
    for (int k = 8; k >= 1; k--) begin
      if (k == 1) check("underflow after 8 returns", bus.stk_underflow, 0);
      at_pc(11'(11'h031 + 16 * k), RET, '0);
    end
    check("underflow after 9 returns", bus.stk_underflow, 1);
    at_pc(11'h0B3, JMP, 11'h7FE);
    wait_pc(11'h7FF);
    check("pc wrap rom_addr", bus.rom_addr, 11'h000);
    wait_pc(11'h003);
    bus.ir_ready = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async reset ir_valid", bus.ir_valid, 0);
    check("async reset rom_addr", bus.rom_addr, 0);
    check("async reset ir", bus.ir, 0);
    check("async reset overflow", bus.stk_overflow, 0);
    check("async reset underflow", bus.stk_underflow, 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    bus.ir_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("restart rom_addr", bus.rom_addr, 11'h006);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/program_fetch_unit.md
Name: program_fetch_unit

Overview:
Instruction-fetch front end that drives the program ROM address and captures the returned 14-bit instruction word. It owns the program counter, the fetch/execute instruction register and an 8-level hardware return stack. It serves GOTO/CALL/RETURN redirects and skip-flushes requested by the execute stage, so instructions are supplied in PIC16-style two-stage-pipeline order. The unit sits between the combinational program ROM and the core decode/execute logic.

Parameters:
ADDR_W, 11, program address width (2048-word ROM)
INSTR_W, 14, instruction word width
STACK_DEPTH, 8, return-stack entries (power of two)
RESET_VECTOR, 0, PC value after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rom_addr  output  ADDR_W  program ROM address; equals the registered PC
rom_data  input  INSTR_W  ROM word for rom_addr, valid combinationally in the same cycle
ir  output  INSTR_W  instruction register presented to execute
ir_valid  output  1  ir holds a live instruction
ir_ready  input  1  execute consumes ir this cycle
ir_pc  output  ADDR_W  address ir was fetched from
jmp_req  input  1  GOTO: load PC from jmp_target
call_req  input  1  CALL: push return address, then load PC from jmp_target
ret_req  input  1  RETURN/RETLW/RETFIE: pop PC from stack
skip_req  input  1  discard the next sequential instruction
jmp_target  input  ADDR_W  redirect target
stk_overflow  output  1  sticky; set on a push while the stack is full
stk_underflow  output  1  sticky; set on a pop while the stack is empty

Behaviour:
- Reset (async, rst_n=0): PC=RESET_VECTOR; ir=0; ir_valid=0; ir_pc=0; stack pointer=0; count=0; both flags=0. All storage registers clear. No fetch is lost: the first rising edge after release captures ROM[RESET_VECTOR].
- consume = ir_valid & ir_ready. advance = consume | ~ir_valid.
- jmp_req, call_req, ret_req and skip_req are sampled only when consume=1. They are ignored otherwise.
- Sequential fetch (advance=1, no redirect): ir<=rom_data; ir_pc<=PC; ir_valid<=1; PC<=PC+1, wrapping from 0x7FF to 0x000.
- Stall (ir_valid=1, ir_ready=0): PC, ir, ir_pc and the stack hold. rom_addr stays stable.
- GOTO: PC<=jmp_target; ir_valid<=0 (the in-flight fetch is flushed). The target instruction appears in ir one cycle later. Branch penalty = 1 bubble.
- CALL: push the current PC (address of the call + 1), then behave as GOTO.
- RETURN: PC<=top of stack; pop; ir_valid<=0.
- Skip: ir<=0x0000 (NOP); ir_pc<=PC; ir_valid<=1; PC<=PC+1. The skipped word is fetched and replaced by NOP, so timing matches the two-cycle skip.
- Priority when several requests arrive in one consume cycle: ret_req > call_req > jmp_req > skip_req. Lower-priority requests are dropped.
- Stack is circular with STACK_DEPTH entries:
  - Push when count=STACK_DEPTH overwrites the oldest entry and sets stk_overflow; count stays at STACK_DEPTH.
  - Pop when count=0 returns the entry at the decremented pointer and sets stk_underflow; count stays 0. PC still loads that value.
  - Flags clear only on reset.
- rom_addr is always PC; no combinational path from any input to rom_addr.
- Reset asserted mid-stall or mid-redirect: everything returns to reset values immediately. No partial push is retained.

Decomposition:
- Shared package pfu_pkg:
  - constants: ADDR_W, INSTR_W, STACK_DEPTH, RESET_VECTOR, NOP_WORD=14'h0000
  - redirect-kind enum: NONE, SKIP, JMP, CALL, RET
  - function for wrap-increment of the PC
- Sub-module pfu_call_stack: circular LIFO with push, pop, push_data, top, overflow/underflow pulses and the same clk/rst_n. The top level owns the PC, the IR and the priority encoder.

Test Plan:
- Reset then ir_ready=1 with ROM[0]=0x3009, ROM[1]=0x00A4 -> rom_addr 0x000 during reset; 1st edge ir=0x3009, ir_pc=0; 2nd edge ir=0x00A4, ir_pc=1; rom_addr=0x002.
- GOTO: consume ir at 0x00E with jmp_req=1, target 0x00B -> next cycle ir_valid=0, rom_addr=0x00B; following cycle ir=ROM[0x00B], ir_pc=0x00B.
- CALL at 0x010 to 0x020, then RETURN at 0x025 -> after the return bubble, ir_pc=0x011. stk_overflow and stk_underflow stay 0.
- Skip at ir_pc=0x00D -> next ir=0x0000 with ir_pc=0x00E, then ir_pc=0x00F holds ROM[0x00F].
- Stall ir_ready=0 for 5 cycles with jmp_req=1 -> PC, ir and rom_addr are unchanged and the redirect is ignored. Releasing resumes sequential fetch.
- 9 CALLs without RETURN -> stk_overflow=1 after the 9th. Then 9 RETURNs -> the 8 newest addresses are returned in LIFO order, and stk_underflow=1 after the 9th. Also: PC at 0x7FF wraps to 0x000, and rst_n low mid-stall clears ir_valid asynchronously.
